// File: rtl/spi_pkg.sv
// Shared SPI link definitions: frame width, receiver states, line idle levels.
package spi_pkg;

    localparam int SPI_DATA_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TAIL  = 2'd3
    } rx_state_t;

    localparam logic CS_IDLE   = 1'b1;
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer with idle-level preset and one-cycle edge strobes.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: syncs cs/sclk/mosi, shifts LSB-first on sclk fall,
// qualifies the frame on cs rise and offers it on a valid/ready port.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int LEAD_EDGES  = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              sclk,
    input  logic              mosi,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam int LW = (LEAD_EDGES > 1) ? $clog2(LEAD_EDGES + 1) : 1;

    logic cs_rise, cs_fall, sclk_fall, mosi_s;
    logic cs_lvl_unused, sclk_lvl_unused, sclk_rise_unused;
    logic mosi_rise_unused, mosi_fall_unused;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CS_IDLE)) u_cs (
        .clk(clk), .rst_n(rst_n), .d(cs),
        .q(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk),
        .q(sclk_lvl_unused), .rise(sclk_rise_unused), .fall(sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(MOSI_IDLE)) u_mosi (
        .clk(clk), .rst_n(rst_n), .d(mosi),
        .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    rx_state_t         state, state_n;
    logic [BW-1:0]     bitcnt;
    logic [LW-1:0]     lcnt;
    logic [DATA_W-1:0] shreg;
    logic clr, lead_inc, shift, good, ferr, accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // cs_rise takes priority so a coincident sclk edge is never shifted
    always_comb begin
        state_n  = state;
        clr      = 1'b0;
        lead_inc = 1'b0;
        shift    = 1'b0;
        good     = 1'b0;
        ferr     = 1'b0;
        if (state != IDLE && cs_rise) begin
            state_n = IDLE;
            good    = (state == TAIL);
            ferr    = (state != TAIL);
        end else begin
            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        clr     = 1'b1;
                        state_n = (LEAD_EDGES == 0) ? SHIFT : LEAD;
                    end
                end
                LEAD: begin
                    if (sclk_fall) begin
                        lead_inc = 1'b1;
                        if (lcnt == LW'(LEAD_EDGES - 1)) state_n = SHIFT;
                    end
                end
                SHIFT: begin
                    if (sclk_fall) begin
                        shift = 1'b1;
                        if (bitcnt == BW'(DATA_W - 1)) state_n = TAIL;
                    end
                end
                TAIL: ;
            endcase
        end
    end

    assign accept = good && (!rx_valid || rx_ready);
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt    <= '0;
            lcnt      <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr;
            overrun   <= good && !accept;
            if (clr) begin
                bitcnt <= '0;
                lcnt   <= '0;
                shreg  <= '0;
            end
            if (lead_inc) lcnt <= lcnt + 1'b1;
            if (shift) begin
                shreg  <= {mosi_s, shreg[DATA_W-1:1]};
                bitcnt <= bitcnt + 1'b1;
            end
            if (accept) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx driven with the 12-bit transmitter waveform.
module tb_spi_slave_rx;
    import spi_pkg::*;

    localparam int HP = 11;
    localparam int DW = SPI_DATA_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs = 1'b1;
    logic          sclk = 1'b0;
    logic          mosi = 1'b0;
    logic          rx_ready = 1'b1;
    logic [DW-1:0] rx_data;
    logic          rx_valid, busy, frame_err, overrun;

    int total = 0;
    int bad = 0;
    int ferr_seen = 0, ferr_exp = 0;
    int ovr_seen = 0, ovr_exp = 0;
    int valid_cycles = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    spi_slave_rx dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .sclk(sclk), .mosi(mosi),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .frame_err(frame_err), .overrun(overrun)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Monitor: pops the scoreboard on every handshake, counts flag pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) ferr_seen++;
            if (overrun) ovr_seen++;
            if (rx_valid) valid_cycles++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_word: got %0h want none", rx_data);
                end else begin
                    chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Reference: a frame is good when at least lead+DW falling edges arrive
    // before cs rises; the coincident edge in 'coinc' mode does not count.
    task automatic send_frame(input logic [DW-1:0] data, input int ndata,
                              input int trail, input bit coinc);
        int nb;
        int edges;
        nb = 1 + ndata + trail;
        edges = nb - (coinc ? 1 : 0);
        if (edges >= 1 + DW) begin
            if (exp_q.size() > 0 && !rx_ready) ovr_exp++;
            else exp_q.push_back(data);
        end else begin
            ferr_exp++;
        end
        cs = 1'b0;
        wclk(HP);
        for (int b = 0; b < nb; b++) begin
            sclk = 1'b1;
            mosi = (b >= 1 && b <= ndata) ? data[b-1] : 1'b0;
            wclk(HP);
            sclk = 1'b0;
            if (coinc && b == nb - 1) cs = 1'b1;
            else wclk(HP);
        end
        cs = 1'b1;
        wclk(2 * HP);
        chk("frame_err_count", 32'(ferr_seen), 32'(ferr_exp));
        chk("overrun_count", 32'(ovr_seen), 32'(ovr_exp));
    endtask

    initial begin
        int vc0;
        logic [DW-1:0] d;
        int n;
        int tr;

        wclk(2);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", 32'({frame_err, overrun}), 0);
        rst_n = 1'b1;
        wclk(4);

        vc0 = valid_cycles;
        send_frame(12'hA5C, DW, 1, 1'b0);
        chk("valid_one_cycle", 32'(valid_cycles - vc0), 1);

        rx_ready = 1'b0;
        send_frame(12'h001, DW, 1, 1'b0);
        send_frame(12'h800, DW, 1, 1'b0);
        chk("held_data", 32'(rx_data), 32'h001);
        chk("held_valid", 32'(rx_valid), 1);
        rx_ready = 1'b1;
        wclk(1);
        chk("valid_drop", 32'(rx_valid), 0);

        send_frame(12'h000, 5, 0, 1'b0);
        chk("short_no_valid", 32'(rx_valid), 0);
        send_frame(12'hFFF, DW, 1, 1'b0);

        send_frame(12'h3C3, DW, 4, 1'b0);

        cs = 1'b0;
        wclk(HP);
        for (int b = 0; b <= 6; b++) begin
            sclk = 1'b1;
            mosi = (b >= 1) ? 1'(b % 2) : 1'b0;
            wclk(HP);
            sclk = 1'b0;
            wclk(HP);
        end
        chk("busy_mid_frame", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs",
            32'({rx_valid, busy, frame_err, overrun}), 0);
        chk("midrst_data", 32'(rx_data), 0);
        cs = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        wclk(2);
        rst_n = 1'b1;
        wclk(2 * HP);
        send_frame(12'h2AA, DW, 1, 1'b0);

        send_frame(12'h6B9, DW, 0, 1'b1);
        chk("coinc_no_valid", 32'(rx_valid), 0);

        for (int i = 0; i < 20; i++) begin
            rx_ready = ($urandom_range(0, 3) != 0);
            d = DW'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                n = $urandom_range(0, DW - 1);
                tr = 0;
            end else begin
                n = DW;
                tr = $urandom_range(1, 4);
            end
            send_frame(d, n, tr, 1'b0);
        end

        rx_ready = 1'b1;
        wclk(5);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- Receive-side stage downstream of the team's 12-bit SPI transmitter. Consumes its cs/sclk/mosi wires and rebuilds each 12-bit word in the system clock domain.
- Sync inputs, detect sclk falling edges, shift in LSB-first, qualify the frame on cs rise.
- Present the word on a valid/ready output with frame-error and overrun flags.
- Sits between the SPI pins and the consuming datapath or register block.

Parameters:
- DATA_W, 12: bits per frame; the first captured bit lands in rx_data[0].
- LEAD_EDGES, 1: sclk falling edges discarded after cs falls, before data capture. Covers the transmitter's idle bit between cs assert and bit 0.
- SYNC_STAGES, 2: flop stages on each of cs, sclk and mosi (minimum 2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cs  in  1  SPI chip select, active low, asynchronous to clk.
- sclk  in  1  SPI clock, asynchronous to clk, idles low.
- mosi  in  1  SPI data; changes on sclk rise, so it is sampled on sclk fall.
- rx_data  out  DATA_W  last good word; held until the next good frame is accepted.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready at a clk edge.
- busy  out  1  high from synced cs fall until synced cs rise.
- frame_err  out  1  one-cycle pulse: cs rose with a captured bit count other than DATA_W.
- overrun  out  1  one-cycle pulse: good frame completed while rx_valid=1 and rx_ready=0.

Behaviour:
- Reset (rst_n=0, async): sync chains preset to line idle (cs=1, sclk=0, mosi=0). State IDLE; rx_data=0; rx_valid=0; busy=0; frame_err=0; overrun=0; bit counter=0; shift register=0.
- Edge detect: act on the last sync stage against a one-flop-delayed copy. cs_fall, cs_rise and sclk_fall are each one-cycle strobes.
- State IDLE:
  - cs_fall -> LEAD; clear counters; busy=1.
  - sclk edges are ignored.
- State LEAD:
  - Each sclk_fall increments the lead counter.
  - When the counter reaches LEAD_EDGES -> SHIFT.
  - If LEAD_EDGES=0, go straight to SHIFT from IDLE.
- State SHIFT:
  - Each sclk_fall: shreg <= {mosi_s, shreg[DATA_W-1:1]}; bitcnt++.
  - When bitcnt reaches DATA_W -> TAIL.
- State TAIL: further sclk edges are ignored. This covers the transmitter's trailing zero bit.
- cs_rise, in any non-IDLE state -> IDLE; busy=0.
  - If state==TAIL, this is a good frame:
    - rx_valid=0, or rx_ready=1 in the same cycle: rx_data<=shreg, rx_valid stays/goes 1.
    - Otherwise: rx_data and rx_valid are unchanged, overrun pulses and the new word is dropped.
  - Any other state: frame_err pulses; rx_data and rx_valid are untouched.
- Simultaneous strobes: cs_rise beats sclk_fall in the same cycle, and the edge is not shifted. cs_fall while already non-IDLE cannot occur.
- rx_valid clears on rx_valid && rx_ready, unless a good frame loads in the same cycle.
- Latency: rx_valid rises 1 clk after cs_rise is detected, i.e. ≤ SYNC_STAGES+2 clk after the cs pin rises.
- Input constraint: sclk half-period ≥ SYNC_STAGES+2 clk. The transmitter's 11-clk half-period meets this.
- Reset mid-frame: immediate IDLE; partial data is lost with no error pulse. The next cs_fall starts cleanly.

Decomposition:
- spi_pkg holds:
  - the DATA_W default, shared with the transmitter;
  - the rx state enum (IDLE, LEAD, SHIFT, TAIL), 2-bit encoding;
  - the idle-level constants for cs/sclk/mosi.
- Sub-module spi_sync: SYNC_STAGES-deep synchronizer with reset preset value and rise/fall strobes. Instantiated once each for cs, sclk and mosi; mosi strobes are unused.

Test Plan:
- Drive the transmitter waveform (11-clk half-period) with din=12'hA5C and rx_ready=1 -> rx_data=12'hA5C, rx_valid=1 for exactly 1 cycle; frame_err=0, overrun=0.
- Frames 12'h001 then 12'h800 with rx_ready=0 -> rx_data stays 12'h001 and rx_valid stays 1; overrun pulses once on the second cs rise. Then raise rx_ready -> rx_valid drops the next cycle.
- cs rises after 5 data edges -> frame_err pulses once; rx_valid stays 0; the following full frame 12'hFFF is received correctly.
- Frame with 3 extra sclk cycles before cs rise, data 12'h3C3 -> rx_data=12'h3C3; extra edges are ignored and no error is flagged.
- rst_n low for 2 clk after bit 6 of frame 12'h555 -> all outputs 0 and busy=0 immediately. The next frame 12'h2AA is received correctly.
- cs_rise and sclk_fall forced into the same synced clk cycle while in SHIFT with bitcnt=DATA_W-1 -> frame_err pulses and no word is delivered.
